// File: rtl/srl_fifo_ctrl.sv
// Shift-register FIFO: an enable-only DEPTH x WIDTH shift chain (SRL-mappable)
// with an occupancy counter that gates the shift and addresses the read tap.
module srl_fifo_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AFULL = DEPTH - 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] chain [DEPTH];
  logic [CW-1:0]    count_nxt;
  logic [AW-1:0]    tap;
  logic             push;
  logic             pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // No reset on the chain so it maps onto SRL primitives; out_valid hides stale data.
  always_ff @(posedge clk) begin
    if (push) begin
      chain[0] <= in_data;
      for (int k = 1; k < int'(DEPTH); k++) begin
        chain[k] <= chain[k-1];
      end
    end
  end

  // Newest word sits at chain[0], so the oldest lives at address count-1.
  assign tap      = AW'(count - CW'(1));
  assign out_data = chain[tap];

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  // Status flags are registered alongside count so they carry no input paths.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      count       <= count_nxt;
      in_ready    <= (count_nxt != CW'(DEPTH));
      out_valid   <= (count_nxt != '0);
      almost_full <= (count_nxt >= CW'(AFULL));
    end
  end

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Directed bench for srl_fifo_ctrl (WIDTH=8, DEPTH=16, AFULL=14).
module tb_srl_fifo_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFULL = 14;
  localparam int unsigned CW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             almost_full;

  int n_tests = 0;
  int n_fail  = 0;

  srl_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          out_ready;
    logic [CW-1:0] exp_count;
    logic          exp_valid;
    logic          exp_ready;
    logic          exp_afull;
    logic [7:0]    exp_data;
  } vec_t;

  vec_t vecs[$];

  // Expected flags follow directly from the hand-computed expected occupancy.
  function automatic void add(input logic r, input logic f, input logic iv,
                              input logic [7:0] d, input logic ordy,
                              input int c, input logic [7:0] ed);
    vec_t v;
    v.rst = r; v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
    v.exp_count = CW'(c);
    v.exp_valid = (c != 0);
    v.exp_ready = (c != 16);
    v.exp_afull = (c >= 14);
    v.exp_data  = ed;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string nm, input int c, input logic [7:0] d);
    chk({nm, ".count"}, int'(count), c);
    chk({nm, ".out_valid"}, int'(out_valid), int'(c != 0));
    chk({nm, ".in_ready"}, int'(in_ready), int'(c != 16));
    chk({nm, ".almost_full"}, int'(almost_full), int'(c >= 14));
    if (c != 0) chk({nm, ".out_data"}, int'(out_data), int'(d));
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [7:0] d, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // reset, then pop attempt on empty is ignored
    add(1, 0, 0, 8'h00, 0, 0, 8'h00);
    add(0, 0, 0, 8'h00, 1, 0, 8'h00);
    // fill 0x01..0x10, oldest stays 0x01
    for (int i = 1; i <= 16; i++) add(0, 0, 1, 8'(i), 0, i, 8'h01);
    // push while full stalls
    add(0, 0, 1, 8'h11, 0, 16, 8'h01);
    // drain: after k pops the oldest is k+1
    for (int k = 1; k <= 16; k++) add(0, 0, 0, 8'h00, 1, 16 - k, 8'(k + 1));
    // fall-through from empty, then pop
    add(0, 0, 1, 8'hA5, 0, 1, 8'hA5);
    add(0, 0, 0, 8'h00, 1, 0, 8'h00);
    // flush at count 9 with push and pop active
    for (int i = 0; i < 9; i++) add(0, 0, 1, 8'(8'h50 + i), 0, i + 1, 8'h50);
    add(0, 1, 1, 8'h77, 1, 0, 8'h00);
    add(0, 0, 1, 8'h3C, 0, 1, 8'h3C);
    add(0, 0, 0, 8'h00, 1, 0, 8'h00);
    // reset mid-stream at count 5 with push active
    for (int i = 0; i < 5; i++) add(0, 0, 1, 8'(8'h60 + i), 0, i + 1, 8'h60);
    add(1, 0, 1, 8'h99, 0, 0, 8'h00);
    add(0, 0, 1, 8'h6E, 0, 1, 8'h6E);
    add(0, 0, 0, 8'h00, 1, 0, 8'h00);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      chk($sformatf("vec%0d.count", i), int'(count), int'(vecs[i].exp_count));
      chk($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d.in_ready", i), int'(in_ready), int'(vecs[i].exp_ready));
      chk($sformatf("vec%0d.almost_full", i), int'(almost_full), int'(vecs[i].exp_afull));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d.out_data", i), int'(out_data), int'(vecs[i].exp_data));
    end

    // streaming: preload 3 then push+pop for 40 cycles
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 8'(8'h40 + i), 0);
      q.push_back(8'(8'h40 + i));
    end
    check_outs("preload", 3, q[0]);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("stream%0d.count", i), int'(count), 3);
      chk($sformatf("stream%0d.out_data", i), int'(out_data), int'(q[0]));
      drive(0, 0, 1, 8'(8'h43 + i), 1);
      q.push_back(8'(8'h43 + i));
      void'(q.pop_front());
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tail%0d.out_data", i), int'(out_data), int'(q[0]));
      drive(0, 0, 0, 8'h00, 1);
      void'(q.pop_front());
    end
    check_outs("stream_end", 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/srl_fifo_ctrl.md
Name: srl_fifo_ctrl

Overview:
- Shift-register FIFO: a DEPTH x WIDTH shift chain with a common shift enable plus an occupancy controller.
- The controller drives the chain's shift enable and selects the read tap.
- The chain is built from plain enable-only flops (no reset, no init), so synthesis maps it onto SRL primitives.
- Sits between a valid/ready producer and consumer as a small, cheap elastic buffer.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 16, number of chain entries; legal range 2..128.
- AFULL, DEPTH-2, almost_full asserts when count >= AFULL; legal range 1..DEPTH.
- CW (localparam), $clog2(DEPTH+1), width of count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of occupancy.
- in_data  in  WIDTH  write data.
- in_valid  in  1  write request.
- in_ready  out  1  FIFO can accept a word.
- out_data  out  WIDTH  oldest word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data.
- count  out  CW  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AFULL.

Behaviour:
- State is held in count, a registered counter. Decoded states: EMPTY (count==0), PARTIAL, FULL (count==DEPTH).
- push = in_valid & in_ready. in_ready = (count != DEPTH), a function of registered state only; no combinational path from out_ready.
- pop = out_valid & out_ready. out_valid = (count != 0).
- Chain: on push, chain[0] <= in_data and chain[k] <= chain[k-1] for k=1..DEPTH-1. The chain enable is exactly push; chain flops are never reset, flushed or initialised.
- Read tap: out_data = chain[count-1], a combinational mux on registered count (SRL address = count-1). out_data is don't-care when out_valid=0; the bench must not check it then.
- Count update, in priority order:
  - rst: count <= 0.
  - else flush: count <= 0. A push in the same cycle still shifts the chain but the word is discarded.
  - else push & !pop: count <= count+1.
  - else pop & !push: count <= count-1.
  - else (both or neither): count unchanged.
- Push and pop in the same cycle: the oldest word is consumed and the next-oldest moves into tap count-1. Only legal when PARTIAL: in_ready=0 when FULL and out_valid=0 when EMPTY.
- Latency: a word pushed into EMPTY appears on out_data/out_valid the cycle after the push edge, so 1-cycle fall-through.
- Throughput: 1 word/cycle with continuous push+pop.
- Ordering: strict FIFO. Words are never lost or duplicated except via flush or rst.
- Reset values: count=0, out_valid=0, in_ready=1, almost_full=0 (requires AFULL>=1). out_data is unspecified.
- Reset mid-operation: occupancy is lost immediately at the next edge. Stale chain contents are never presented, because out_valid=0 until the next push.
- Overflow/underflow cannot occur by construction. in_valid while FULL stalls; out_ready while EMPTY is ignored.
- count never exceeds DEPTH; there is no wrap-around.

Test Plan:
- Reset then fill (WIDTH=8, DEPTH=16, out_ready=0): push 0x01..0x10 on consecutive cycles.
  - count steps 1..16.
  - almost_full rises when count reaches 14.
  - in_ready drops when count reaches 16.
  - The push of 0x11 stalls; count stays 16.
- Drain from FULL (in_valid=0, out_ready=1): out_data yields 0x01..0x10 in order over 16 cycles; out_valid falls at count=0.
- Simultaneous streaming: preload 3 words, then push and pop every cycle for 40 cycles. count holds 3 and the output sequence equals the input sequence delayed by 3 words.
- Fall-through: with FIFO EMPTY, push 0xA5. The next cycle has out_valid=1, out_data=0xA5, count=1. Pop, and the following cycle has count=0.
- Flush: at count=9, assert flush with push and pop both active. Next cycle count=0, out_valid=0, in_ready=1. The next push of 0x3C is the next word out.
- Reset mid-stream: at count=5 with push active, assert rst for 1 cycle. Then count=0, out_valid=0, almost_full=0. The first subsequent push is the first word read back.
